// File: rtl/memory_access_stage.sv
// Purpose: MEM pipeline stage: loads/stores against an internal sync data RAM, registers the MEM/WB bundle.
// Latency: 1 cycle from the EX/MEM bundle to the registered MEM/WB outputs; forwarding outputs follow the registers.
// Backpressure: none; a new bundle is accepted every cycle with no stall or handshake.
//
// Ports:
//   clk, resetN                  clock and asynchronous active-low reset
//   writeBackControlIn[1:0]      {regWrite, memToReg}
//   memAccessControlIn[2:0]      {byteAccess, memRead, memWrite}
//   result, writeData, rdIn      effective byte address / ALU result, store data, destination register
//   writeBackControlOut, readData, aluResult, rdOut, alignError   registered MEM/WB bundle
//   memWbRegWrite, memWbRd, memWbData                              forwarding back into Execute
//   ledOut                       memory-mapped LED register
//
// Optional feature: define MEM_LED_PORT_EN to map an 8-bit LED register at word address 32'hFFFF_FFFC.
// Without it, ledOut is tied to 0 and that address is an ordinary wrapped RAM location.

module memory_access_stage #(
  parameter int    ADDR_WIDTH = 8,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [1:0]  writeBackControlIn,
  input  logic [2:0]  memAccessControlIn,
  input  logic [31:0] result,
  input  logic [31:0] writeData,
  input  logic [4:0]  rdIn,
  output logic [1:0]  writeBackControlOut,
  output logic [31:0] readData,
  output logic [31:0] aluResult,
  output logic [4:0]  rdOut,
  output logic        memWbRegWrite,
  output logic [4:0]  memWbRd,
  output logic [31:0] memWbData,
  output logic        alignError,
  output logic [7:0]  ledOut
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] mem [DEPTH];

  logic                  byte_acc;
  logic                  mem_rd;
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [1:0]            lane;
  logic [31:0]           ram_word;
  logic                  misalign;
  logic                  led_hit;
  logic                  ram_we;
  logic [7:0]            led_val;

  assign byte_acc = memAccessControlIn[2];
  assign mem_rd   = memAccessControlIn[1];
  assign mem_wr   = memAccessControlIn[0];
  // Upper address bits are dropped, so accesses wrap modulo the RAM size.
  assign word_idx = result[ADDR_WIDTH+1:2];
  assign lane     = result[1:0];
  assign ram_word = mem[word_idx];

`ifdef MEM_LED_PORT_EN
  localparam bit LedEn = 1'b1;

  logic [7:0] led_q;
  logic [7:0] led_d;

  always_comb begin
    led_d = led_q;
    if (mem_wr && led_hit) led_d = writeData[7:0];
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) led_q <= 8'h00;
    else         led_q <= led_d;
  end

  assign led_val = led_q;
`else
  localparam bit LedEn = 1'b0;

  assign led_val = 8'h00;
`endif

  always_comb begin
    misalign = !byte_acc && (mem_rd || mem_wr) && (lane != 2'b00);
    // Only word accesses decode the LED register; byte accesses there go to RAM.
    led_hit  = LedEn && !byte_acc && (result == 32'hFFFF_FFFC);
    ram_we   = mem_wr && !misalign && !led_hit;
  end

  // RAM write port. Gating with resetN drops a store that coincides with reset.
  always_ff @(posedge clk) begin
    if (resetN && ram_we) begin
      if (byte_acc) mem[word_idx][{lane, 3'b000} +: 8] <= writeData[7:0];
      else          mem[word_idx] <= writeData;
    end
  end

  logic [1:0]  wb_q,    wb_d;
  logic [31:0] read_q,  read_d;
  logic [31:0] alu_q,   alu_d;
  logic [4:0]  rd_q,    rd_d;
  logic        align_q, align_d;

  always_comb begin
    read_d = 32'h0;
    // A combined read+write performs only the store; the load side returns 0.
    if (mem_rd && !mem_wr && !misalign) begin
      if (byte_acc)     read_d = {24'h0, ram_word[{lane, 3'b000} +: 8]};
      else if (led_hit) read_d = {24'h0, led_val};
      else              read_d = ram_word;
    end
    // r0 is never written; a misaligned access must not retire a write-back.
    wb_d[1] = writeBackControlIn[1] && (rdIn != 5'd0) && !misalign;
    wb_d[0] = writeBackControlIn[0] && !(mem_rd && mem_wr);
    alu_d   = result;
    rd_d    = rdIn;
    align_d = misalign;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wb_q    <= 2'b00;
      read_q  <= 32'h0;
      alu_q   <= 32'h0;
      rd_q    <= 5'd0;
      align_q <= 1'b0;
    end else begin
      wb_q    <= wb_d;
      read_q  <= read_d;
      alu_q   <= alu_d;
      rd_q    <= rd_d;
      align_q <= align_d;
    end
  end

  assign writeBackControlOut = wb_q;
  assign readData            = read_q;
  assign aluResult           = alu_q;
  assign rdOut               = rd_q;
  assign alignError          = align_q;
  assign ledOut              = led_val;
  assign memWbRegWrite       = wb_q[1];
  assign memWbRd             = rd_q;
  assign memWbData           = wb_q[0] ? read_q : alu_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Purpose: self-checking bench for memory_access_stage: directed scenarios plus randomized traffic.
// Latency: expects every registered output one clock after the inputs are presented.
// Backpressure: none exercised; the stage is driven with a new bundle every cycle.

module tb_memory_access_stage;

  logic        clk = 1'b0;
  logic        resetN;
  logic [1:0]  writeBackControlIn;
  logic [2:0]  memAccessControlIn;
  logic [31:0] result;
  logic [31:0] writeData;
  logic [4:0]  rdIn;
  logic [1:0]  writeBackControlOut;
  logic [31:0] readData;
  logic [31:0] aluResult;
  logic [4:0]  rdOut;
  logic        memWbRegWrite;
  logic [4:0]  memWbRd;
  logic [31:0] memWbData;
  logic        alignError;
  logic [7:0]  ledOut;

  always #5 clk = ~clk;

  memory_access_stage dut (
    .clk                 (clk),
    .resetN              (resetN),
    .writeBackControlIn  (writeBackControlIn),
    .memAccessControlIn  (memAccessControlIn),
    .result              (result),
    .writeData           (writeData),
    .rdIn                (rdIn),
    .writeBackControlOut (writeBackControlOut),
    .readData            (readData),
    .aluResult           (aluResult),
    .rdOut               (rdOut),
    .memWbRegWrite       (memWbRegWrite),
    .memWbRd             (memWbRd),
    .memWbData           (memWbData),
    .alignError          (alignError),
    .ledOut              (ledOut)
  );

`ifdef MEM_LED_PORT_EN
  localparam bit LED_EN = 1'b1;
`else
  localparam bit LED_EN = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: byte-addressed little-endian memory (1024 bytes for ADDR_WIDTH=8) plus LED value.
  logic [7:0]  mb [1024];
  logic [7:0]  led_m;

  logic [1:0]  exp_wb;
  logic [31:0] exp_rdata;
  logic [31:0] exp_alu;
  logic [4:0]  exp_rdo;
  logic        exp_align;
  logic [31:0] exp_data;

  // Presents one bundle, predicts the outputs from the architectural rules, then advances one clock.
  task automatic step(input logic [1:0] wb, input logic [2:0] mac, input logic [31:0] res,
                      input logic [31:0] wd, input logic [4:0] rd);
    logic [9:0] b;
    logic [9:0] w;
    logic       is_word;
    logic       mis;
    logic       led;
    writeBackControlIn = wb;
    memAccessControlIn = mac;
    result             = res;
    writeData          = wd;
    rdIn               = rd;
    b       = res[9:0];
    w       = {res[9:2], 2'b00};
    is_word = !mac[2];
    mis     = is_word && (mac[1] || mac[0]) && (res[1:0] != 2'b00);
    led     = LED_EN && is_word && (res == 32'hFFFF_FFFC);
    exp_rdata = 32'h0;
    if (mac[1] && !mac[0] && !mis) begin
      if (!is_word)  exp_rdata = {24'h0, mb[b]};
      else if (led)  exp_rdata = {24'h0, led_m};
      else           exp_rdata = {mb[w+3], mb[w+2], mb[w+1], mb[w]};
    end
    if (mac[0] && !mis) begin
      if (!is_word)  mb[b] = wd[7:0];
      else if (led)  led_m = wd[7:0];
      else for (int k = 0; k < 4; k++) mb[w+k] = wd[8*k +: 8];
    end
    exp_wb    = {wb[1] && (rd != 5'd0) && !mis, wb[0] && !(mac[1] && mac[0])};
    exp_alu   = res;
    exp_rdo   = rd;
    exp_align = mis;
    exp_data  = exp_wb[0] ? exp_rdata : res;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    writeBackControlIn = 2'b00;
    memAccessControlIn = 3'b000;
    result             = 32'h0;
    writeData          = 32'h0;
    rdIn               = 5'd0;
    led_m              = 8'h00;
    resetN = 1'b1;
    #1 resetN = 1'b0;
    #1;
    checks++; if (writeBackControlOut !== 2'b00) begin errors++; $display("FAIL reset_wb got %b exp 00", writeBackControlOut); end
    checks++; if (readData !== 32'h0) begin errors++; $display("FAIL reset_readData got %h exp 0", readData); end
    checks++; if (aluResult !== 32'h0) begin errors++; $display("FAIL reset_aluResult got %h exp 0", aluResult); end
    checks++; if (rdOut !== 5'd0) begin errors++; $display("FAIL reset_rdOut got %0d exp 0", rdOut); end
    checks++; if (alignError !== 1'b0) begin errors++; $display("FAIL reset_alignError got %b exp 0", alignError); end
    checks++; if (ledOut !== 8'h00) begin errors++; $display("FAIL reset_ledOut got %h exp 0", ledOut); end
    @(posedge clk);
    @(posedge clk);
    #1 resetN = 1'b1;
  endtask

  task automatic test_word_store_load();
    step(2'b00, 3'b001, 32'h10, 32'hDEADBEEF, 5'd0);
    step(2'b11, 3'b010, 32'h10, 32'h0, 5'd5);
    checks++; if (readData !== 32'hDEADBEEF) begin errors++; $display("FAIL wl_readData got %h exp deadbeef", readData); end
    checks++; if (memWbData !== 32'hDEADBEEF) begin errors++; $display("FAIL wl_memWbData got %h exp deadbeef", memWbData); end
    checks++; if (memWbRd !== 5'd5) begin errors++; $display("FAIL wl_memWbRd got %0d exp 5", memWbRd); end
    checks++; if (memWbRegWrite !== 1'b1) begin errors++; $display("FAIL wl_memWbRegWrite got %b exp 1", memWbRegWrite); end
    checks++; if (writeBackControlOut !== 2'b11) begin errors++; $display("FAIL wl_wb got %b exp 11", writeBackControlOut); end
  endtask

  task automatic test_byte_access();
    step(2'b00, 3'b001, 32'h10, 32'h11223344, 5'd0);
    step(2'b00, 3'b101, 32'h11, 32'hFFFFFF55, 5'd0);
    step(2'b11, 3'b010, 32'h10, 32'h0, 5'd6);
    checks++; if (readData !== 32'h11225544) begin errors++; $display("FAIL bs_word_readData got %h exp 11225544", readData); end
    step(2'b11, 3'b110, 32'h11, 32'h0, 5'd7);
    checks++; if (readData !== 32'h00000055) begin errors++; $display("FAIL bl_lane1 got %h exp 00000055", readData); end
    checks++; if (memWbData !== 32'h00000055) begin errors++; $display("FAIL bl_memWbData got %h exp 00000055", memWbData); end
    step(2'b11, 3'b110, 32'h13, 32'h0, 5'd7);
    checks++; if (readData !== 32'h00000011) begin errors++; $display("FAIL bl_lane3 got %h exp 00000011", readData); end
  endtask

  task automatic test_misaligned();
    step(2'b11, 3'b010, 32'h12, 32'h0, 5'd9);
    checks++; if (alignError !== 1'b1) begin errors++; $display("FAIL mis_load_align got %b exp 1", alignError); end
    checks++; if (readData !== 32'h0) begin errors++; $display("FAIL mis_load_readData got %h exp 0", readData); end
    checks++; if (writeBackControlOut[1] !== 1'b0) begin errors++; $display("FAIL mis_load_regWrite got %b exp 0", writeBackControlOut[1]); end
    checks++; if (aluResult !== 32'h12) begin errors++; $display("FAIL mis_load_aluResult got %h exp 12", aluResult); end
    step(2'b00, 3'b001, 32'h12, 32'hCAFEF00D, 5'd0);
    checks++; if (alignError !== 1'b1) begin errors++; $display("FAIL mis_store_align got %b exp 1", alignError); end
    step(2'b11, 3'b010, 32'h10, 32'h0, 5'd9);
    checks++; if (alignError !== 1'b0) begin errors++; $display("FAIL mis_clear_align got %b exp 0", alignError); end
    checks++; if (readData !== 32'h11225544) begin errors++; $display("FAIL mis_ram_unchanged got %h exp 11225544", readData); end
  endtask

  task automatic test_nonmem_and_rw();
    step(2'b10, 3'b000, 32'h1234, 32'h0, 5'd0);
    checks++; if (aluResult !== 32'h1234) begin errors++; $display("FAIL nm_aluResult got %h exp 1234", aluResult); end
    checks++; if (writeBackControlOut !== 2'b00) begin errors++; $display("FAIL nm_wb got %b exp 00", writeBackControlOut); end
    checks++; if (memWbRegWrite !== 1'b0) begin errors++; $display("FAIL nm_memWbRegWrite got %b exp 0", memWbRegWrite); end
    checks++; if (memWbData !== 32'h1234) begin errors++; $display("FAIL nm_memWbData got %h exp 1234", memWbData); end
    step(2'b11, 3'b011, 32'h20, 32'h0BADF00D, 5'd4);
    checks++; if (readData !== 32'h0) begin errors++; $display("FAIL rw_readData got %h exp 0", readData); end
    checks++; if (writeBackControlOut !== 2'b10) begin errors++; $display("FAIL rw_wb got %b exp 10", writeBackControlOut); end
    checks++; if (memWbData !== 32'h20) begin errors++; $display("FAIL rw_memWbData got %h exp 20", memWbData); end
    step(2'b11, 3'b010, 32'h20, 32'h0, 5'd4);
    checks++; if (readData !== 32'h0BADF00D) begin errors++; $display("FAIL rw_store_done got %h exp 0badf00d", readData); end
  endtask

  task automatic test_reset_mid_store();
    step(2'b00, 3'b001, 32'h30, 32'h5A5A5A5A, 5'd0);
    step(2'b11, 3'b010, 32'h30, 32'h0, 5'd6);
    writeBackControlIn = 2'b00;
    memAccessControlIn = 3'b001;
    result             = 32'h30;
    writeData          = 32'h12345678;
    rdIn               = 5'd3;
    #3 resetN = 1'b0;
    #1;
    checks++; if (writeBackControlOut !== 2'b00) begin errors++; $display("FAIL rst_mid_wb got %b exp 00", writeBackControlOut); end
    checks++; if (readData !== 32'h0) begin errors++; $display("FAIL rst_mid_readData got %h exp 0", readData); end
    checks++; if (aluResult !== 32'h0) begin errors++; $display("FAIL rst_mid_aluResult got %h exp 0", aluResult); end
    checks++; if (rdOut !== 5'd0) begin errors++; $display("FAIL rst_mid_rdOut got %0d exp 0", rdOut); end
    checks++; if (memWbData !== 32'h0) begin errors++; $display("FAIL rst_mid_memWbData got %h exp 0", memWbData); end
    @(posedge clk);
    #1 resetN = 1'b1;
    led_m = 8'h00;
    step(2'b11, 3'b010, 32'h30, 32'h0, 5'd6);
    checks++; if (readData !== 32'h5A5A5A5A) begin errors++; $display("FAIL rst_mid_ram_kept got %h exp 5a5a5a5a", readData); end
  endtask

  task automatic test_led();
    logic [31:0] exp_word;
    step(2'b00, 3'b001, 32'h3FC, 32'h77777777, 5'd0);
    step(2'b00, 3'b001, 32'hFFFF_FFFC, 32'h000000A5, 5'd0);
    checks++; if (ledOut !== (LED_EN ? 8'hA5 : 8'h00)) begin errors++; $display("FAIL led_ledOut got %h exp %h", ledOut, LED_EN ? 8'hA5 : 8'h00); end
    step(2'b11, 3'b010, 32'hFFFF_FFFC, 32'h0, 5'd3);
    checks++; if (readData !== 32'h000000A5) begin errors++; $display("FAIL led_load got %h exp 000000a5", readData); end
    step(2'b11, 3'b010, 32'h3FC, 32'h0, 5'd3);
    exp_word = LED_EN ? 32'h77777777 : 32'h000000A5;
    checks++; if (readData !== exp_word) begin errors++; $display("FAIL led_ram_word got %h exp %h", readData, exp_word); end
  endtask

  task automatic test_random();
    logic [31:0] tmp;
    logic [31:0] res;
    logic [7:0]  idx;
    for (int i = 0; i < 256; i++) begin
      idx = i[7:0];
      step(2'b00, 3'b001, {22'h0, idx, 2'b00}, $urandom(), 5'd0);
    end
    for (int i = 0; i < 800; i++) begin
      tmp = $urandom();
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: res = {tmp[31:10], tmp[9:2], 2'b00};
        6, 7:             res = {22'h0, tmp[9:0]};
        8:                res = 32'hFFFF_FFFC;
        default:          res = tmp;
      endcase
      step(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), res, $urandom(), 5'($urandom_range(0, 31)));
      checks++; if (writeBackControlOut !== exp_wb) begin errors++; $display("FAIL rand_wb op %0d got %b exp %b", i, writeBackControlOut, exp_wb); end
      checks++; if (readData !== exp_rdata) begin errors++; $display("FAIL rand_readData op %0d got %h exp %h", i, readData, exp_rdata); end
      checks++; if (aluResult !== exp_alu) begin errors++; $display("FAIL rand_aluResult op %0d got %h exp %h", i, aluResult, exp_alu); end
      checks++; if (rdOut !== exp_rdo) begin errors++; $display("FAIL rand_rdOut op %0d got %0d exp %0d", i, rdOut, exp_rdo); end
      checks++; if (memWbRegWrite !== exp_wb[1]) begin errors++; $display("FAIL rand_memWbRegWrite op %0d got %b exp %b", i, memWbRegWrite, exp_wb[1]); end
      checks++; if (memWbRd !== exp_rdo) begin errors++; $display("FAIL rand_memWbRd op %0d got %0d exp %0d", i, memWbRd, exp_rdo); end
      checks++; if (memWbData !== exp_data) begin errors++; $display("FAIL rand_memWbData op %0d got %h exp %h", i, memWbData, exp_data); end
      checks++; if (alignError !== exp_align) begin errors++; $display("FAIL rand_alignError op %0d got %b exp %b", i, alignError, exp_align); end
      checks++; if (ledOut !== (LED_EN ? led_m : 8'h00)) begin errors++; $display("FAIL rand_ledOut op %0d got %h exp %h", i, ledOut, LED_EN ? led_m : 8'h00); end
    end
  endtask

  initial begin
    test_reset();
    test_word_store_load();
    test_byte_access();
    test_misaligned();
    test_nonmem_and_rw();
    test_reset_mid_store();
    test_led();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
